// File: rtl/ucsbece152a_ssd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ucsbece152a_ssd_pkg
// Description : Seven-segment pattern constants and the state encodings used
//               by the segment stream decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package ucsbece152a_ssd_pkg;

    // Segment order {a,b,c,d,e,f,g}, bit 6 = a, active-high
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Pattern tracker: still counting repeats, or already reported
    typedef enum logic [0:0] {
        TRK_ACQUIRE = 1'b0,
        TRK_LOCKED  = 1'b1
    } trk_state_t;

    // One-entry output holding register
    typedef enum logic [0:0] {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

endpackage : ucsbece152a_ssd_pkg
`default_nettype wire

// File: rtl/ucsbece152a_ssd_pattern_decode.sv
`default_nettype none
// ============================================================================
// Module      : ucsbece152a_ssd_pattern_decode
// Description : Combinational seven-segment pattern classifier. Reports
//               whether a pattern is a legal digit 0..7, whether it is
//               blank, and the digit value for legal patterns.
// Revision    : 1.0 - initial release
// ============================================================================
module ucsbece152a_ssd_pattern_decode
    import ucsbece152a_ssd_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic       o_legal,
    output logic       o_blank,
    output logic [2:0] o_digit
);

    // Pattern lookup; anything unlisted is neither legal nor blank
    always_comb begin
        o_legal = 1'b1;
        o_blank = 1'b0;
        o_digit = 3'd0;
        case (i_seg)
            SEG_0:     o_digit = 3'd0;
            SEG_1:     o_digit = 3'd1;
            SEG_2:     o_digit = 3'd2;
            SEG_3:     o_digit = 3'd3;
            SEG_4:     o_digit = 3'd4;
            SEG_5:     o_digit = 3'd5;
            SEG_6:     o_digit = 3'd6;
            SEG_7:     o_digit = 3'd7;
            SEG_BLANK: begin
                o_legal = 1'b0;
                o_blank = 1'b1;
            end
            default:   o_legal = 1'b0;
        endcase
    end

endmodule : ucsbece152a_ssd_pattern_decode
`default_nettype wire

// File: rtl/ucsbece152a_ssdr.sv
`default_nettype none
// ============================================================================
// Module      : ucsbece152a_ssdr
// Description : Seven-segment stream reader. Debounces a sampled segment
//               pattern (STABLE_CNT identical accepted samples lock it),
//               decodes locked digits into a one-entry valid/ready output
//               register, flags illegal patterns and sticky overflow.
//               Optional feature macro: SSDR_ERR_CNT_EN adds err_cnt_o, a
//               saturating count of err_o pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module ucsbece152a_ssdr
    import ucsbece152a_ssd_pkg::*;
#(
    parameter int STABLE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_valid_i,
    input  logic [6:0] seg_i,
    output logic [2:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       err_o,
    output logic       overflow_o
`ifdef SSDR_ERR_CNT_EN
    ,
    output logic [7:0] err_cnt_o
`endif
);

    localparam logic [3:0] C_STABLE = 4'(STABLE_CNT);

    // Tracker state
    trk_state_t r_trk_state;
    trk_state_t w_trk_state_nxt;
    logic [3:0] r_count;
    logic [3:0] w_count_nxt;
    logic [6:0] r_last_seg;
    logic [6:0] w_last_seg_nxt;
    logic       w_lock;

    // Output register state
    out_state_t r_out_state;
    out_state_t w_out_state_nxt;
    logic [2:0] r_data;
    logic [2:0] w_data_nxt;
    logic       r_ovf;
    logic       w_ovf_nxt;
    logic       r_err;

    // Classification of the pattern currently being sampled
    logic       w_legal;
    logic       w_blank;
    logic [2:0] w_digit;
    logic       w_push;
    logic       w_err_set;

    ucsbece152a_ssd_pattern_decode u_decode (
        .i_seg   (seg_i),
        .o_legal (w_legal),
        .o_blank (w_blank),
        .o_digit (w_digit)
    );

    // A lock event always refers to seg_i, since a locking sample matches last_seg
    assign w_push    = w_lock & w_legal;
    assign w_err_set = w_lock & ~w_legal & ~w_blank;

    // Tracker registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_trk_state <= TRK_ACQUIRE;
            r_count     <= 4'd0;
            r_last_seg  <= SEG_BLANK;
        end else begin
            r_trk_state <= w_trk_state_nxt;
            r_count     <= w_count_nxt;
            r_last_seg  <= w_last_seg_nxt;
        end
    end

    // Tracker next state: restart on change, count repeats, lock once
    always_comb begin
        w_trk_state_nxt = r_trk_state;
        w_count_nxt     = r_count;
        w_last_seg_nxt  = r_last_seg;
        w_lock          = 1'b0;
        if (sample_valid_i) begin
            if (seg_i != r_last_seg) begin
                w_last_seg_nxt  = seg_i;
                w_count_nxt     = 4'd1;
                w_trk_state_nxt = TRK_ACQUIRE;
            end else if (r_trk_state == TRK_ACQUIRE) begin
                w_count_nxt = r_count + 4'd1;
                if (r_count + 4'd1 == C_STABLE) begin
                    w_trk_state_nxt = TRK_LOCKED;
                    w_lock          = 1'b1;
                end
            end
        end
    end

    // Output holding register, overflow flag and error pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_state <= OUT_EMPTY;
            r_data      <= 3'd0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_out_state <= w_out_state_nxt;
            r_data      <= w_data_nxt;
            r_ovf       <= w_ovf_nxt;
            r_err       <= w_err_set;
        end
    end

    // Output next state: a push into a full register only lands if it is popped this cycle
    always_comb begin
        w_out_state_nxt = r_out_state;
        w_data_nxt      = r_data;
        w_ovf_nxt       = r_ovf;
        case (r_out_state)
            OUT_EMPTY: begin
                if (w_push) begin
                    w_out_state_nxt = OUT_FULL;
                    w_data_nxt      = w_digit;
                end
            end
            OUT_FULL: begin
                if (w_push) begin
                    if (ready_i) begin
                        w_data_nxt = w_digit;
                    end else begin
                        w_ovf_nxt = 1'b1;
                    end
                end else if (ready_i) begin
                    w_out_state_nxt = OUT_EMPTY;
                end
            end
            default: w_out_state_nxt = OUT_EMPTY;
        endcase
    end

    assign data_o     = r_data;
    assign valid_o    = (r_out_state == OUT_FULL);
    assign err_o      = r_err;
    assign overflow_o = r_ovf;

`ifdef SSDR_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    // Count rises together with the err_o pulse it accounts for
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_cnt <= 8'd0;
        end else if (w_err_set && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt_o = r_err_cnt;
`endif

endmodule : ucsbece152a_ssdr
`default_nettype wire

// File: tb/tb_ucsbece152a_ssdr.sv
`default_nettype none
// ============================================================================
// Module      : tb_ucsbece152a_ssdr
// Description : Self-checking bench for ucsbece152a_ssdr against a
//               run-length reference model of the segment stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ucsbece152a_ssdr;

    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sample_valid_i;
    logic [6:0] seg_i;
    logic [2:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       err_o;
    logic       overflow_o;
    logic [7:0] err_cnt;

`ifdef SSDR_ERR_CNT_EN
    localparam bit HAS_CNT = 1'b1;
`else
    localparam bit HAS_CNT = 1'b0;
    assign err_cnt = 8'd0;
`endif

    ucsbece152a_ssdr #(.STABLE_CNT(STABLE)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sample_valid_i (sample_valid_i),
        .seg_i          (seg_i),
        .data_o         (data_o),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .err_o          (err_o),
        .overflow_o     (overflow_o)
`ifdef SSDR_ERR_CNT_EN
        ,
        .err_cnt_o      (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: last pattern, its run length, one output slot
    logic [6:0] m_last;
    int         m_run;
    bit         m_full;
    logic [2:0] m_data;
    bit         m_err;
    bit         m_ovf;
    int         m_cnt;

    logic [6:0] pat_tab [8] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000};

    logic [13:0] got;
    assign got = {valid_o, data_o, err_o, overflow_o, err_cnt};

    function automatic logic [13:0] exp_vec();
        logic [7:0] c;
        c = HAS_CNT ? 8'(m_cnt) : 8'd0;
        return {m_full, m_data, m_err, m_ovf, c};
    endfunction

    function automatic int lookup(input logic [6:0] s);
        for (int k = 0; k < 8; k++)
            if (pat_tab[k] == s) return k;
        return -1;
    endfunction

    // Apply one clock of stimulus; advance the model; return 1 us after the edge
    task automatic step(input bit rstn, input bit sv, input logic [6:0] seg, input bit rdy);
        bit lock;
        int idx;
        rst_n = rstn; sample_valid_i = sv; seg_i = seg; ready_i = rdy;
        if (!rstn) begin
            m_last = 7'd0; m_run = 0; m_full = 0; m_data = 3'd0;
            m_err = 0; m_ovf = 0; m_cnt = 0;
        end else begin
            lock = 0;
            if (sv) begin
                if (seg == m_last) begin
                    if (m_run < 100) m_run++;
                end else begin
                    m_last = seg;
                    m_run  = 1;
                end
                lock = (m_run == STABLE);
            end
            idx   = lookup(seg);
            m_err = lock && (idx < 0) && (seg != 7'd0);
            if (m_err && m_cnt < 255) m_cnt++;
            if (lock && idx >= 0) begin
                if (!m_full || rdy) begin
                    m_full = 1;
                    m_data = 3'(idx);
                end else begin
                    m_ovf = 1;
                end
            end else if (m_full && rdy) begin
                m_full = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(0, 0, 7'd0, 1);
        step(0, 0, 7'd0, 1);
        checks++;
        if (got !== 14'd0) begin
            errors++;
            $display("FAIL reset got=%h want=%h", got, 14'd0);
        end
    endtask

    task automatic test_digit5();
        int pushes = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 7'b1011011, 1);
            checks++;
            if (got !== exp_vec()) begin
                errors++;
                $display("FAIL digit5 cyc%0d got=%h want=%h", i, got, exp_vec());
            end
            if (valid_o) pushes++;
            if (i == 3) begin
                checks++;
                if (valid_o !== 1'b1 || data_o !== 3'd5) begin
                    errors++;
                    $display("FAIL digit5_lat valid=%b data=%0d want valid=1 data=5", valid_o, data_o);
                end
            end
        end
        checks++;
        if (pushes != 1) begin
            errors++;
            $display("FAIL digit5_once pushes=%0d want=1", pushes);
        end
    endtask

    task automatic test_interrupted();
        logic [6:0] seq [8] = '{7'b1111001, 7'b1111001, 7'b1111001, 7'b0110000,
                                7'b1111001, 7'b1111001, 7'b1111001, 7'b1111001};
        int pushes = 0;
        step(0, 0, 7'd0, 1);
        for (int i = 0; i < 10; i++) begin
            step(1, i < 8, (i < 8) ? seq[i] : 7'd0, 1);
            checks++;
            if (got !== exp_vec()) begin
                errors++;
                $display("FAIL interrupted cyc%0d got=%h want=%h", i, got, exp_vec());
            end
            if (valid_o) begin
                pushes++;
                checks++;
                if (i != 7 || data_o !== 3'd3) begin
                    errors++;
                    $display("FAIL interrupted_push cyc=%0d data=%0d want cyc=7 data=3", i, data_o);
                end
            end
        end
        checks++;
        if (pushes != 1) begin
            errors++;
            $display("FAIL interrupted_once pushes=%0d want=1", pushes);
        end
    endtask

    task automatic test_illegal();
        int pulses = 0;
        step(0, 0, 7'd0, 1);
        for (int i = 0; i < 7; i++) begin
            step(1, i < 5, 7'b1111111, 1);
            checks++;
            if (got !== exp_vec()) begin
                errors++;
                $display("FAIL illegal cyc%0d got=%h want=%h", i, got, exp_vec());
            end
            if (err_o) pulses++;
            checks++;
            if (valid_o !== 1'b0) begin
                errors++;
                $display("FAIL illegal_novalid valid=%b want=0", valid_o);
            end
        end
        checks++;
        if (pulses != 1 || err_cnt !== (HAS_CNT ? 8'd1 : 8'd0)) begin
            errors++;
            $display("FAIL illegal_pulse pulses=%0d cnt=%0d want pulses=1", pulses, err_cnt);
        end
    endtask

    task automatic test_overflow();
        step(0, 0, 7'd0, 0);
        for (int i = 0; i < 8; i++) begin
            step(1, 1, (i < 4) ? 7'b1101101 : 7'b1110000, 0);
            checks++;
            if (got !== exp_vec()) begin
                errors++;
                $display("FAIL overflow cyc%0d got=%h want=%h", i, got, exp_vec());
            end
        end
        checks++;
        if (data_o !== 3'd2 || valid_o !== 1'b1 || overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL overflow_hold data=%0d valid=%b ovf=%b want 2 1 1", data_o, valid_o, overflow_o);
        end
        step(1, 0, 7'd0, 1);
        checks++;
        if (valid_o !== 1'b0 || overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL overflow_pop valid=%b ovf=%b want 0 1", valid_o, overflow_o);
        end
    endtask

    task automatic test_blank_gaps();
        step(0, 0, 7'd0, 1);
        for (int i = 0; i < 8; i++) begin
            step(1, i[0], 7'd0, 1);
            checks++;
            if (got !== exp_vec() || valid_o !== 1'b0 || err_o !== 1'b0) begin
                errors++;
                $display("FAIL blank cyc%0d got=%h want=%h", i, got, exp_vec());
            end
        end
        // Gapped samples of a legal digit must still lock
        for (int i = 0; i < 8; i++) begin
            step(1, i[0], 7'b1011111, 1);
            checks++;
            if (got !== exp_vec()) begin
                errors++;
                $display("FAIL gaps cyc%0d got=%h want=%h", i, got, exp_vec());
            end
            if (i == 7) begin
                checks++;
                if (valid_o !== 1'b1 || data_o !== 3'd6) begin
                    errors++;
                    $display("FAIL gaps_lock valid=%b data=%0d want 1 6", valid_o, data_o);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1, 1, 7'b0110000, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 7'b0110000, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 7'b0110011, 0);
        step(0, 1, 7'b0110011, 0);
        checks++;
        if (got !== 14'd0) begin
            errors++;
            $display("FAIL reset_mid got=%h want=%h", got, 14'd0);
        end
        step(1, 1, 7'b0110011, 1);
        step(1, 0, 7'd0, 1);
        checks++;
        if (valid_o !== 1'b0 || got !== exp_vec()) begin
            errors++;
            $display("FAIL reset_mid_nopush got=%h want=%h", got, exp_vec());
        end
    endtask

    task automatic test_random();
        logic [6:0] p;
        int sel;
        int hold;
        step(0, 0, 7'd0, 1);
        for (int n = 0; n < 250; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 8)       p = pat_tab[sel];
            else if (sel == 8) p = 7'd0;
            else               p = 7'($urandom);
            hold = $urandom_range(1, 7);
            for (int h = 0; h < hold; h++) begin
                step(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0), p,
                     ($urandom_range(0, 2) != 0));
                checks++;
                if (got !== exp_vec()) begin
                    errors++;
                    $display("FAIL random n%0d h%0d got=%h want=%h", n, h, got, exp_vec());
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; sample_valid_i = 1'b0; seg_i = 7'd0; ready_i = 1'b1;
        test_reset();
        test_digit5();
        test_interrupted();
        test_illegal();
        test_overflow();
        test_blank_gaps();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ucsbece152a_ssdr
`default_nettype wire

// File: doc/ucsbece152a_ssdr.md
UCSBECE152A_SSDR -- requirements
Module: ucsbece152a_ssdr

Interface
REQ-001 Parameter: STABLE_CNT, default 4, number of consecutive identical accepted samples needed to lock a pattern; legal range 2..15.
REQ-002 Ports: clk  input  1  single clock; all logic on rising edge.
REQ-003 Ports: rst_n  input  1  synchronous, active-low reset.
REQ-004 Ports: sample_valid_i  input  1  seg_i is sampled this cycle.
REQ-005 Ports: seg_i  input  7  segment pattern {a,b,c,d,e,f,g}, bit6=a, active-high.
REQ-006 Ports: data_o  output  3  decoded digit 0..7.
REQ-007 Ports: valid_o  output  1  data_o holds an unconsumed digit.
REQ-008 Ports: ready_i  input  1  consumer accepts data_o when valid_o=1.
REQ-009 Ports: err_o  output  1  one-cycle pulse: a locked pattern is not a legal digit.
REQ-010 Ports: overflow_o  output  1  sticky: a decoded digit was dropped because the output was full.
REQ-011 Ports: err_cnt_o  output  8  invalid-pattern count (only with SSDR_ERR_CNT_EN).

Function
REQ-012 Legal patterns SHALL be 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000; blank=0000000.
REQ-013 Tracker FSM SHALL have states ACQUIRE and LOCKED; cycles with sample_valid_i=0 change nothing in the tracker.
REQ-014 Accepted sample differing from last_seg SHALL load last_seg=seg_i, set count=1, go to ACQUIRE.
REQ-015 Accepted sample equal to last_seg in ACQUIRE SHALL increment count; on reaching STABLE_CNT go to LOCKED and raise one lock event that cycle.
REQ-016 In LOCKED, equal samples SHALL raise no further events; count saturates at STABLE_CNT.
REQ-017 Lock event on blank SHALL be ignored: no push, no err_o, no count.
REQ-018 Lock event on a legal pattern SHALL push its digit to the output register; data_o/valid_o update the next cycle (latency 1 after the locking sample).
REQ-019 Lock event on an illegal, non-blank pattern SHALL pulse err_o the next cycle for exactly one cycle and push nothing.
REQ-020 Output register states EMPTY/FULL; valid_o=1 iff FULL; valid_o&&ready_i pops (FULL->EMPTY).
REQ-021 Push while FULL and ready_i=0 SHALL drop the new digit, keep data_o unchanged, set overflow_o=1 until reset.
REQ-022 Push and pop in the same cycle SHALL load the new digit, keep valid_o=1, no overflow.
REQ-023 data_o SHALL be held stable while valid_o=1 and ready_i=0.

Reset
REQ-024 rst_n=0 at a clock edge SHALL set: state ACQUIRE, count=0, last_seg=0000000, data_o=0, valid_o=0, err_o=0, overflow_o=0, err_cnt_o=0.
REQ-025 Reset mid-acquisition or with valid_o=1 SHALL discard all pending data; the first post-reset sample starts a new acquisition (count=1 unless it is blank matching last_seg, then count=1 via REQ-015 increment from 0).

Configuration
REQ-026 Macro SSDR_ERR_CNT_EN defined: err_cnt_o present, increments by 1 on every err_o pulse, saturates at 255.
REQ-027 Macro SSDR_ERR_CNT_EN undefined: err_cnt_o port and counter absent; all other behaviour identical.

Structure
REQ-028 Package ucsbece152a_ssd_pkg SHALL hold the nine segment constants (SEG_0..SEG_7, SEG_BLANK), tracker and output state enums.
REQ-029 Sub-module ucsbece152a_ssd_pattern_decode SHALL be combinational: 7-bit pattern -> {legal, blank, digit[2:0]}.

Verification (STABLE_CNT=4, ready_i=1 unless stated)
REQ-030 Four consecutive valid samples 1011011 -> valid_o=1, data_o=5 one cycle after the fourth; no second push while held.
REQ-031 Samples 1111001 x3, 0110000, 1111001 x4 -> single push of 3 only after the last four; no push of 1.
REQ-032 Four samples 1111111 -> err_o one-cycle pulse, valid_o stays 0, err_cnt_o=1 (with macro).
REQ-033 ready_i=0; lock 2 (1101101) then lock 7 (1110000) -> data_o=2 held, overflow_o=1; ready_i=1 -> valid_o falls.
REQ-034 Four blank samples -> no valid_o, no err_o; sample_valid_i gaps between samples do not reset count.
REQ-035 rst_n=0 after three samples of 0110011 -> all outputs 0; one post-reset sample of 0110011 does not push.
